// File: rtl/vr_vc_if.sv
// Bundle of the valid/ready upstream and valid/credit downstream signals around
// the converter; slave is the converter's view, master is the surrounding environment.
interface vr_vc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
);
  localparam int CW = $clog2(CREDIT_NUM + 1);

  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_valid_o;
  logic                  m_credit_i;
  logic [CW-1:0]         credit_cnt_o;
  logic                  credit_err_o;

  modport slave (
    input  s_data_i, s_valid_i, m_credit_i,
    output s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_err_o
  );

  modport master (
    output s_data_i, s_valid_i, m_credit_i,
    input  s_ready_o, m_data_o, m_valid_o, credit_cnt_o, credit_err_o
  );
endinterface

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter: accepts an upstream beat only while a
// downstream credit is held, forwards it through one output register.
module vr_vc_converter #(
  parameter int DATA_WIDTH  = 8,
  parameter int CREDIT_NUM  = 2,
  parameter int INIT_CREDIT = CREDIT_NUM
) (
  input  logic      clk,
  input  logic      rst_n,
  vr_vc_if.slave    bus
);
  localparam int            CW       = $clog2(CREDIT_NUM + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CREDIT_NUM);
  localparam logic [CW-1:0] CNT_INIT = CW'(INIT_CREDIT);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  vld_p1_q, vld_p1_d;
  logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
  logic                  ready;
  logic                  fire;
  logic                  ovf;
  logic [CW:0]           cnt_sum;

  // Clamp the widened count at the receiver depth; an excess only comes from a
  // spurious credit pulse, which is flagged separately.
  function automatic logic [CW-1:0] sat_credit(input logic [CW:0] sum);
    if (sum > {1'b0, CNT_MAX}) return CNT_MAX;
    return sum[CW-1:0];
  endfunction

  always_comb begin
    ready   = (cnt_q != '0);
    fire    = bus.s_valid_i & ready;
    ovf     = bus.m_credit_i & (cnt_q == CNT_MAX) & ~fire;
    cnt_sum = {1'b0, cnt_q} - {{CW{1'b0}}, fire} + {{CW{1'b0}}, bus.m_credit_i};
    cnt_d   = sat_credit(cnt_sum);
    err_d   = err_q | ovf;
  end

  // Stage p0 -> p1: capture the accepted beat into the output register
  always_comb begin
    vld_p1_d  = fire;
    data_p1_d = data_p1_q;
    if (fire) data_p1_d = bus.s_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= CNT_INIT;
      err_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      data_p1_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      vld_p1_q  <= vld_p1_d;
      data_p1_q <= data_p1_d;
    end
  end

  assign bus.s_ready_o    = ready;
  assign bus.m_valid_o    = vld_p1_q;
  assign bus.m_data_o     = data_p1_q;
  assign bus.credit_cnt_o = cnt_q;
  assign bus.credit_err_o = err_q;
endmodule

// File: tb/tb_vr_vc_converter.sv
// Directed bench for vr_vc_converter: a vector table on an INIT_CREDIT=2 instance
// and hand-written sequences on an INIT_CREDIT=0 instance.
module tb_vr_vc_converter;
  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vr_vc_if #(.DATA_WIDTH(8), .CREDIT_NUM(2)) ifa ();
  vr_vc_if #(.DATA_WIDTH(8), .CREDIT_NUM(2)) ifb ();

  vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(2), .INIT_CREDIT(2)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ifa.slave));
  vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(2), .INIT_CREDIT(0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(ifb.slave));

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       credit;
    logic       e_ready;
    logic       e_mvalid;
    logic [7:0] e_mdata;
    logic [1:0] e_cnt;
    logic       e_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d,
                              input logic c, input logic er, input logic emv,
                              input logic [7:0] emd, input logic [1:0] ec,
                              input logic ee);
    vec_t t;
    t.rst_n = r; t.valid = v; t.data = d; t.credit = c;
    t.e_ready = er; t.e_mvalid = emv; t.e_mdata = emd; t.e_cnt = ec; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input vec_t t);
    chk({tag, ".ready"},  32'(ifa.s_ready_o),    32'(t.e_ready));
    chk({tag, ".mvalid"}, 32'(ifa.m_valid_o),    32'(t.e_mvalid));
    chk({tag, ".mdata"},  32'(ifa.m_data_o),     32'(t.e_mdata));
    chk({tag, ".cnt"},    32'(ifa.credit_cnt_o), 32'(t.e_cnt));
    chk({tag, ".err"},    32'(ifa.credit_err_o), 32'(t.e_err));
  endtask

  // Drive on the falling edge, step over the rising edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst v  data   cr rdy mv mdata  cnt err
    vecs[0]  = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 2, 0); // reset
    vecs[1]  = mk(1, 0, 8'h00, 0, 1, 0, 8'h00, 2, 0); // idle keeps reset state
    vecs[2]  = mk(1, 1, 8'hAA, 0, 1, 1, 8'hAA, 1, 0); // AA accepted
    vecs[3]  = mk(1, 1, 8'hBB, 0, 0, 1, 8'hBB, 0, 0); // BB accepted, drained
    vecs[4]  = mk(1, 1, 8'hCC, 0, 0, 0, 8'hBB, 0, 0); // CC blocked
    vecs[5]  = mk(1, 1, 8'hCC, 1, 1, 0, 8'hBB, 1, 0); // credit: not accepted yet
    vecs[6]  = mk(1, 1, 8'hCC, 0, 0, 1, 8'hCC, 0, 0); // CC accepted next cycle
    vecs[7]  = mk(1, 0, 8'h00, 1, 1, 0, 8'hCC, 1, 0); // credit back to 1
    vecs[8]  = mk(1, 1, 8'hDD, 1, 1, 1, 8'hDD, 1, 0); // fire + credit
    vecs[9]  = mk(1, 1, 8'hEE, 1, 1, 1, 8'hEE, 1, 0);
    vecs[10] = mk(1, 1, 8'hFF, 1, 1, 1, 8'hFF, 1, 0);
    vecs[11] = mk(1, 0, 8'h00, 1, 1, 0, 8'hFF, 2, 0); // full again
    vecs[12] = mk(1, 0, 8'h00, 1, 1, 0, 8'hFF, 2, 1); // overflow, saturate
    vecs[13] = mk(1, 1, 8'h11, 0, 1, 1, 8'h11, 1, 1); // error sticky
    vecs[14] = mk(1, 0, 8'h00, 1, 1, 0, 8'h11, 2, 1);
    vecs[15] = mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 2, 0); // reset clears error

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    ifa.s_valid_i = 1'b0; ifa.s_data_i = '0; ifa.m_credit_i = 1'b0;
    ifb.s_valid_i = 1'b0; ifb.s_data_i = '0; ifb.m_credit_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_a_n        = vecs[i].rst_n;
      ifa.s_valid_i  = vecs[i].valid;
      ifa.s_data_i   = vecs[i].data;
      ifa.m_credit_i = vecs[i].credit;
      step();
      chk_a($sformatf("vec%0d", i), vecs[i]);
    end

    // Mid-operation reset on instance A: the held beat is dropped.
    @(negedge clk);
    rst_a_n = 1'b1; ifa.s_valid_i = 1'b1; ifa.s_data_i = 8'h77; ifa.m_credit_i = 1'b0;
    step();
    chk("a_fire.mvalid", 32'(ifa.m_valid_o), 32'd1);
    chk("a_fire.cnt",    32'(ifa.credit_cnt_o), 32'd1);
    @(negedge clk);
    rst_a_n = 1'b0; ifa.s_data_i = 8'h88;
    step();
    chk("a_rst.mvalid", 32'(ifa.m_valid_o), 32'd0);
    chk("a_rst.mdata",  32'(ifa.m_data_o), 32'h00);
    chk("a_rst.cnt",    32'(ifa.credit_cnt_o), 32'd2);

    // Instance B: INIT_CREDIT = 0, credits arrive by pulses after reset.
    step();
    chk("b_rst.ready", 32'(ifb.s_ready_o), 32'd0);
    chk("b_rst.cnt",   32'(ifb.credit_cnt_o), 32'd0);
    @(negedge clk);
    rst_b_n = 1'b1; ifb.s_valid_i = 1'b1; ifb.s_data_i = 8'h42;
    step();
    chk("b_blocked.mvalid", 32'(ifb.m_valid_o), 32'd0);
    @(negedge clk);
    ifb.s_valid_i = 1'b0; ifb.m_credit_i = 1'b1;
    step();
    chk("b_cr1.cnt",   32'(ifb.credit_cnt_o), 32'd1);
    chk("b_cr1.ready", 32'(ifb.s_ready_o), 32'd1);
    step();
    chk("b_cr2.cnt", 32'(ifb.credit_cnt_o), 32'd2);
    chk("b_cr2.err", 32'(ifb.credit_err_o), 32'd0);
    @(negedge clk);
    ifb.m_credit_i = 1'b0; ifb.s_valid_i = 1'b1; ifb.s_data_i = 8'h5A; rst_b_n = 1'b0;
    step();
    chk("b_rstfire.mvalid", 32'(ifb.m_valid_o), 32'd0);
    chk("b_rstfire.cnt",    32'(ifb.credit_cnt_o), 32'd0);
    chk("b_rstfire.ready",  32'(ifb.s_ready_o), 32'd0);
    @(negedge clk);
    rst_b_n = 1'b1;
    step();
    chk("b_after.mvalid", 32'(ifb.m_valid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vr_vc_converter.md
Name: vr_vc_converter

Overview:
Converts a valid/ready stream into a valid/credit stream. It is the transmit-side counterpart of vc_vr_converter, which receives valid/credit and drives valid/ready. The block tracks the credits granted by the downstream receiver and accepts an upstream beat only when a credit is held. Each accepted beat is forwarded through a single output register, and each credit-return pulse restores one credit.

Parameters:
DATA_WIDTH, 8, payload width in bits
CREDIT_NUM, 2, maximum credits outstanding (receiver buffer depth); must be >= 1
INIT_CREDIT, CREDIT_NUM, counter value after reset; 0 means the receiver grants all credits by pulses after reset; must be <= CREDIT_NUM

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
s_data_i  input  DATA_WIDTH  upstream payload
s_valid_i  input  1  upstream beat valid
s_ready_o  output  1  upstream may transfer this cycle
m_data_o  output  DATA_WIDTH  downstream payload
m_valid_o  output  1  downstream beat valid, one-cycle pulse per beat
m_credit_i  input  1  one-cycle pulse; returns one credit
credit_cnt_o  output  $clog2(CREDIT_NUM+1)  current credit count
credit_err_o  output  1  sticky; set on credit overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: credit_cnt = INIT_CREDIT, m_valid_o = 0, m_data_o = 0, credit_err_o = 0. Reset has priority over every event in the same cycle.
- Reset mid-operation: any beat held in the output register is dropped without being presented, and the credit count returns to INIT_CREDIT.
- Ready: s_ready_o = (credit_cnt != 0), purely from registered state.
  - s_ready_o has no combinational path from s_valid_i or m_credit_i.
  - A credit returned in cycle N raises s_ready_o in cycle N+1, not in cycle N.
- Fire: fire = s_valid_i & s_ready_o.
- Output register, latency 1 cycle:
  - If fire: m_valid_o <= 1 and m_data_o <= s_data_i.
  - Otherwise: m_valid_o <= 0 and m_data_o holds its value.
  - Back-to-back fires produce back-to-back m_valid_o pulses with no bubble.
  - m_valid_o is never high for a beat that was not accepted.
- Credit counter update: next = credit_cnt - fire + m_credit_i, computed in width+1 bits.
  - Fire and credit in the same cycle: count unchanged, beat forwarded.
  - Fire with credit_cnt == 1 and no credit: count becomes 0 and s_ready_o drops the next cycle.
  - Credit at credit_cnt == 0 with s_valid_i high: count becomes 1. The beat is not accepted that cycle; it is accepted the next cycle.
- Overflow: m_credit_i high while credit_cnt == CREDIT_NUM and no fire.
  - The count saturates at CREDIT_NUM.
  - credit_err_o <= 1 and stays set until reset.
- Underflow cannot occur, because fire requires credit_cnt != 0.
- Invariant: credit_cnt + beats in flight + credits in flight == CREDIT_NUM once all initial credits have been granted.
- No state machine beyond the counter, the output register and the error flag. s_data_i is captured only on fire.
- The upstream side may drop s_valid_i at any time without a handshake violation; there is no stability requirement on the upstream source.

Test Plan:
- Reset with INIT_CREDIT=2: hold rst_n=0 for 1 cycle → credit_cnt_o=2, s_ready_o=1, m_valid_o=0, credit_err_o=0; rst_n high with no traffic keeps these values.
- Drain credits: s_valid_i=1 for 3 cycles with data AA, BB, CC and m_credit_i=0 → m_valid_o pulses with AA then BB on the 2 following cycles; credit_cnt_o goes 2→1→0; s_ready_o=0 in the 3rd cycle; CC is not forwarded.
- Credit release: from the drained state, pulse m_credit_i once while s_valid_i=1 holds CC → credit_cnt_o=1 the next cycle, CC accepted that cycle, m_valid_o with m_data_o=CC one cycle later, count back to 0.
- Simultaneous fire and credit: credit_cnt=1, s_valid_i=1 with DD, m_credit_i=1 → count stays 1, DD forwarded, s_ready_o stays 1; continuous streaming of DD, EE, FF with a credit every cycle gives 3 consecutive m_valid_o pulses.
- Overflow: credit_cnt=2, m_credit_i=1, s_valid_i=0 → credit_cnt_o stays 2, credit_err_o=1 and remains 1 through later traffic until rst_n=0.
- INIT_CREDIT=0 and mid-operation reset:
  - s_ready_o=0 after reset; two m_credit_i pulses → count 2.
  - Assert rst_n=0 in the same cycle as a fire → next cycle m_valid_o=0 and count=0.
